// File: rtl/tneuron_popcount_acc.sv
// Ternary-neuron accumulator: sums (pos_cnt - neg_cnt) over BEATS beats with
// per-beat saturation, then thresholds the frame sum into a ternary activation.
module tneuron_popcount_acc #(
  parameter int unsigned PC_W  = 4,
  parameter int unsigned BEATS = 4,
  parameter int unsigned ACC_W = 8,
  parameter logic signed [ACC_W-1:0] THR_POS = ACC_W'(3),
  parameter logic signed [ACC_W-1:0] THR_NEG = ACC_W'(-3)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PC_W-1:0]         pos_cnt,
  input  logic [PC_W-1:0]         neg_cnt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_act,
  output logic signed [ACC_W-1:0] out_sum
);

  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DIFF_W = ACC_W + 1;
  localparam int unsigned SUM_W  = ACC_W + 2;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {3'b111, {(ACC_W-1){1'b0}}};

  localparam logic [1:0] ACT_POS  = 2'b01;
  localparam logic [1:0] ACT_NEG  = 2'b11;
  localparam logic [1:0] ACT_ZERO = 2'b00;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          beat_cnt, beat_cnt_nxt;
  logic signed [ACC_W-1:0]   acc, acc_nxt;
  logic signed [ACC_W-1:0]   sum_nxt;
  logic [1:0]                act_nxt;

  logic signed [DIFF_W-1:0]  diff_c;
  logic signed [SUM_W-1:0]   acc_x_c, diff_x_c, sum_full_c;
  logic signed [ACC_W-1:0]   sat_sum_c;
  logic [1:0]                act_c;

  // Per-beat difference and saturating add; the extra guard bits keep the
  // unsaturated sum exact so the clamp never sees a wrapped value.
  always_comb begin
    diff_c     = DIFF_W'(pos_cnt) - DIFF_W'(neg_cnt);
    acc_x_c    = {{2{acc[ACC_W-1]}}, acc};
    diff_x_c   = {diff_c[DIFF_W-1], diff_c};
    sum_full_c = acc_x_c + diff_x_c;
    if (sum_full_c > SAT_MAX) begin
      sat_sum_c = SAT_MAX[ACC_W-1:0];
    end else if (sum_full_c < SAT_MIN) begin
      sat_sum_c = SAT_MIN[ACC_W-1:0];
    end else begin
      sat_sum_c = sum_full_c[ACC_W-1:0];
    end
  end

  // Threshold; the positive test wins when the two ranges overlap.
  always_comb begin
    act_c = ACT_ZERO;
    if (sat_sum_c >= THR_POS) begin
      act_c = ACT_POS;
    end else if (sat_sum_c <= THR_NEG) begin
      act_c = ACT_NEG;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACC;
      beat_cnt  <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_act   <= ACT_ZERO;
      out_sum   <= '0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_cnt_nxt;
      acc       <= acc_nxt;
      in_ready  <= (state_nxt == ST_ACC);
      out_valid <= (state_nxt == ST_HOLD);
      out_act   <= act_nxt;
      out_sum   <= sum_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    acc_nxt      = acc;
    sum_nxt      = out_sum;
    act_nxt      = out_act;
    case (state)
      ST_ACC: begin
        if (in_valid && in_ready) begin
          if (beat_cnt == LAST_BEAT) begin
            sum_nxt      = sat_sum_c;
            act_nxt      = act_c;
            acc_nxt      = '0;
            beat_cnt_nxt = '0;
            state_nxt    = ST_HOLD;
          end else begin
            acc_nxt      = sat_sum_c;
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (out_valid && out_ready) begin
          state_nxt = ST_ACC;
        end
      end
      default: state_nxt = ST_ACC;
    endcase
  end

endmodule

// File: tb/tb_tneuron_popcount_acc.sv
// Directed bench: an 8-bit and a 6-bit accumulator run in lockstep on shared
// stimulus, each checked against hand-computed frame sums and activations.
module tb_tneuron_popcount_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [3:0] pos_cnt;
  logic [3:0] neg_cnt;

  logic              in_ready8, out_valid8;
  logic [1:0]        out_act8;
  logic signed [7:0] out_sum8;
  logic              in_ready6, out_valid6;
  logic [1:0]        out_act6;
  logic signed [5:0] out_sum6;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tneuron_popcount_acc #(.PC_W(4), .BEATS(4), .ACC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .pos_cnt(pos_cnt), .neg_cnt(neg_cnt), .out_valid(out_valid8),
    .out_ready(out_ready), .out_act(out_act8), .out_sum(out_sum8)
  );

  tneuron_popcount_acc #(.PC_W(4), .BEATS(4), .ACC_W(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
    .pos_cnt(pos_cnt), .neg_cnt(neg_cnt), .out_valid(out_valid6),
    .out_ready(out_ready), .out_act(out_act6), .out_sum(out_sum6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".rdy"}, 32'(in_ready8), 1);
    check({tag, ".ov"},  32'(out_valid8), 0);
    check({tag, ".act"}, 32'(out_act8), 0);
    check({tag, ".sum"}, $signed(out_sum8), 0);
    check({tag, ".ov6"}, 32'(out_valid6), 0);
    check({tag, ".sum6"}, $signed(out_sum6), 0);
  endtask

  // Four beats (optional idle gap before beat 3), then check both results.
  task automatic frame(input string tag, input int p[4], input int n[4], input int gap,
                       input int s8, input int a8, input int s6, input int a6);
    check({tag, ".rdy"}, 32'(in_ready8), 1);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        repeat (gap) begin
          in_valid = 1'b0;
          @(negedge clk);
          check({tag, ".gap_ov"}, 32'(out_valid8), 0);
        end
      end
      in_valid = 1'b1;
      pos_cnt  = 4'(p[i]);
      neg_cnt  = 4'(n[i]);
      @(negedge clk);
      if (i < 3) check({tag, ".ov_early"}, 32'(out_valid8), 0);
    end
    in_valid = 1'b0;
    check({tag, ".ov"},   32'(out_valid8), 1);
    check({tag, ".rdy_hold"}, 32'(in_ready8), 0);
    check({tag, ".sum"},  $signed(out_sum8), 32'(s8));
    check({tag, ".act"},  32'(out_act8), 32'(a8));
    check({tag, ".ov6"},  32'(out_valid6), 1);
    check({tag, ".sum6"}, $signed(out_sum6), 32'(s6));
    check({tag, ".act6"}, 32'(out_act6), 32'(a6));
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    #1;
    check({tag, ".no_bypass"}, 32'(in_ready8), 0);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".ov_drop"}, 32'(out_valid8), 0);
    check({tag, ".rdy_back"}, 32'(in_ready8), 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pos_cnt = '0; neg_cnt = '0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    frame("b2b_11", '{11, 11, 11, 11}, '{0, 0, 0, 0}, 0, 44, 1, 31, 1);
    take("b2b_11");
    frame("neg4", '{2, 2, 2, 2}, '{3, 3, 3, 3}, 0, -4, 3, -4, 3);
    take("neg4");
    frame("one", '{1, 0, 0, 0}, '{0, 0, 0, 0}, 0, 1, 0, 1, 0);
    take("one");
    frame("thr_p3", '{3, 0, 0, 0}, '{0, 0, 0, 0}, 0, 3, 1, 3, 1);
    take("thr_p3");
    frame("thr_m3", '{0, 0, 0, 0}, '{3, 0, 0, 0}, 0, -3, 3, -3, 3);
    take("thr_m3");
    frame("thr_p2", '{1, 0, 1, 0}, '{0, 0, 0, 0}, 0, 2, 0, 2, 0);
    take("thr_p2");
    frame("thr_m2", '{0, 0, 0, 0}, '{0, 1, 0, 1}, 0, -2, 0, -2, 0);
    take("thr_m2");

    frame("sat_hi", '{15, 15, 15, 15}, '{0, 0, 0, 0}, 0, 60, 1, 31, 1);
    take("sat_hi");
    frame("sat_back", '{15, 15, 15, 0}, '{0, 0, 0, 15}, 0, 30, 1, 16, 1);
    take("sat_back");
    frame("sat_lo", '{0, 0, 0, 0}, '{15, 15, 15, 15}, 0, -60, 3, -32, 3);

    // Backpressure: offered beats must be ignored while the result is held.
    in_valid = 1'b1; pos_cnt = 4'd7; neg_cnt = 4'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp.rdy", 32'(in_ready8), 0);
      check("bp.ov",  32'(out_valid8), 1);
      check("bp.sum", $signed(out_sum8), -60);
      check("bp.act", 32'(out_act8), 3);
    end
    in_valid = 1'b0;
    take("bp");
    frame("after_bp", '{1, 1, 1, 1}, '{0, 0, 0, 0}, 0, 4, 1, 4, 1);
    take("after_bp");

    frame("gap", '{11, 11, 11, 11}, '{0, 0, 0, 0}, 3, 44, 1, 31, 1);

    // Reset while holding a result.
    rst_n = 1'b0;
    #1;
    check_reset("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-frame discards the partial sum and restarts at beat 0.
    in_valid = 1'b1; pos_cnt = 4'd5; neg_cnt = 4'd0;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame("post_rst", '{1, 1, 1, 1}, '{0, 0, 0, 0}, 0, 4, 1, 4, 1);
    take("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
